// File: rtl/muldiv_sched_pkg.sv
// Shared op-code and scheduler state types for the mul/div scheduler slice.
package core_types;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MUL   = 3'd1,
        OP_MULH  = 3'd2,
        OP_MULHU = 3'd3,
        OP_DIV   = 3'd4,
        OP_DIVU  = 3'd5,
        OP_MOD   = 3'd6,
        OP_MODU  = 3'd7
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DIV_RUN,
        S_HOLD,
        S_DRAIN
    } muldiv_state_e;

    function automatic logic is_mul(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_MOD, OP_MODU};
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Requester-side request/grant/response bundle shared by the EX pipes.
interface muldiv_sched_if #(
    parameter int unsigned REQ_NUM = 2
);
    logic [REQ_NUM-1:0]       req_valid_i;
    logic [REQ_NUM-1:0][2:0]  req_op_i;
    logic [REQ_NUM-1:0][31:0] req_rs1_i;
    logic [REQ_NUM-1:0][31:0] req_rs2_i;
    logic [REQ_NUM-1:0]       req_grant_o;
    logic [REQ_NUM-1:0]       resp_valid_o;
    logic [31:0]              resp_result_o;
    logic [REQ_NUM-1:0]       resp_ack_i;

    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, resp_ack_i,
        input  req_grant_o, resp_valid_o, resp_result_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, resp_ack_i,
        output req_grant_o, resp_valid_o, resp_result_o
    );
endinterface

// File: rtl/muldiv_rr_pick.sv
// Fixed-priority one-hot picker: lowest set index wins.
module muldiv_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/muldiv_sched.sv
// Arbitrates EX pipes onto one shared mul_unit and one div_unit, holding each
// result for its owner until acknowledged; flush drains any in-flight unit op.
module muldiv_sched
    import core_types::*;
#(
    parameter int unsigned REQ_NUM = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    muldiv_sched_if.slave req_bus,
    output logic          mul_start_o,
    output logic [1:0]    mul_op_o,
    output logic [31:0]   mul_rs1_o,
    output logic [31:0]   mul_rs2_o,
    output logic          mul_ack_o,
    input  logic          mul_done_i,
    input  logic [31:0]   mul_result_i,
    output logic          div_start_o,
    output logic [1:0]    div_op_o,
    output logic [31:0]   div_dividend_o,
    output logic [31:0]   div_divisor_o,
    input  logic          div_done_i,
    input  logic [31:0]   div_quotient_i,
    input  logic [31:0]   div_remainder_i,
    output logic          busy_o
);
    localparam int unsigned IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    muldiv_state_e      state;
    muldiv_op_e         op_q;
    logic [REQ_NUM-1:0] owner_oh;
    logic [31:0]        rs1_q, rs2_q, result_q;
    logic               mul_start_q, div_start_q;
    logic [REQ_NUM-1:0] resp_valid_q;

    logic [REQ_NUM-1:0] req_live, pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    muldiv_op_e         sel_op;
    logic [31:0]        sel_rs1, sel_rs2;
    logic               owner_ack, unit_done;

    always_comb begin
        req_live = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            req_live[i] = req_bus.req_valid_i[i] && (req_bus.req_op_i[i] != OP_NONE);
        end
    end

    muldiv_rr_pick #(.N(REQ_NUM), .IDX_W(IDX_W)) u_pick (
        .req   (req_live),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign sel_op    = muldiv_op_e'(req_bus.req_op_i[pick_idx]);
    assign sel_rs1   = req_bus.req_rs1_i[pick_idx];
    assign sel_rs2   = req_bus.req_rs2_i[pick_idx];
    assign owner_ack = |(req_bus.resp_ack_i & owner_oh);
    assign unit_done = is_mul(op_q) ? mul_done_i : div_done_i;

    // Grant and unit ack must coincide with the cycle the event is accepted,
    // so they are decoded from the registered state rather than registered.
    assign req_bus.req_grant_o = (state == S_IDLE && !flush && !rst) ? pick_oh : '0;

    always_comb begin
        mul_ack_o = 1'b0;
        if (!rst && is_mul(op_q)) begin
            case (state)
                S_HOLD:    mul_ack_o = flush || owner_ack;
                S_MUL_RUN: mul_ack_o = flush && mul_done_i;
                S_DRAIN:   mul_ack_o = mul_done_i;
                default:   mul_ack_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= OP_NONE;
            owner_oh     <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            result_q     <= '0;
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!flush && pick_any) begin
                        owner_oh <= pick_oh;
                        op_q     <= sel_op;
                        rs1_q    <= sel_rs1;
                        rs2_q    <= sel_rs2;
                        if (is_mul(sel_op)) begin
                            mul_start_q <= 1'b1;
                            state       <= S_MUL_RUN;
                        end else if (sel_rs2 != '0) begin
                            div_start_q <= 1'b1;
                            state       <= S_DIV_RUN;
                        end else begin
                            result_q     <= is_rem(sel_op) ? sel_rs1 : '0;
                            resp_valid_q <= pick_oh;
                            state        <= S_HOLD;
                        end
                    end
                end
                S_MUL_RUN: begin
                    if (flush) begin
                        state <= mul_done_i ? S_IDLE : S_DRAIN;
                    end else if (mul_done_i) begin
                        result_q     <= mul_result_i;
                        resp_valid_q <= owner_oh;
                        state        <= S_HOLD;
                    end
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        state <= div_done_i ? S_IDLE : S_DRAIN;
                    end else if (div_done_i) begin
                        result_q     <= is_rem(op_q) ? div_remainder_i : div_quotient_i;
                        resp_valid_q <= owner_oh;
                        state        <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (flush || owner_ack) begin
                        resp_valid_q <= '0;
                        state        <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (unit_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mul_start_o           = mul_start_q;
    assign mul_op_o              = op_q[1:0];
    assign mul_rs1_o             = rs1_q;
    assign mul_rs2_o             = rs2_q;
    assign div_start_o           = div_start_q;
    assign div_op_o              = op_q[1:0];
    assign div_dividend_o        = rs1_q;
    assign div_divisor_o         = rs2_q;
    assign req_bus.resp_valid_o  = resp_valid_q;
    assign req_bus.resp_result_o = result_q;
    assign busy_o                = (state != S_IDLE);
endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched with behavioural mul/div unit models.
module tb_muldiv_sched;
    import core_types::*;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    muldiv_sched_if #(.REQ_NUM(2)) bus ();

    logic        mul_start, mul_ack, mul_done;
    logic [1:0]  mul_op;
    logic [31:0] mul_rs1, mul_rs2, mul_res;
    logic        div_start, div_done;
    logic [1:0]  div_op;
    logic [31:0] div_a, div_b, div_q, div_r;
    logic        busy;

    muldiv_sched #(.REQ_NUM(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .req_bus         (bus),
        .mul_start_o     (mul_start),
        .mul_op_o        (mul_op),
        .mul_rs1_o       (mul_rs1),
        .mul_rs2_o       (mul_rs2),
        .mul_ack_o       (mul_ack),
        .mul_done_i      (mul_done),
        .mul_result_i    (mul_res),
        .div_start_o     (div_start),
        .div_op_o        (div_op),
        .div_dividend_o  (div_a),
        .div_divisor_o   (div_b),
        .div_done_i      (div_done),
        .div_quotient_i  (div_q),
        .div_remainder_i (div_r),
        .busy_o          (busy)
    );

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        is_mul;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_ack_cyc = -1;
    int   last_grant_cyc = -1;
    int   last_div_done_cyc = -1;
    int   mul_lat = 2;
    int   div_lat = 4;
    int   mul_cnt, div_cnt;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (div_done) last_div_done_cyc <= cyc;

    function automatic logic [31:0] mul_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = {32'b0, a} * {32'b0, b};
        case (op)
            2'b01:   return ps[31:0];
            2'b10:   return ps[63:32];
            default: return pu[63:32];
        endcase
    endfunction

    // mul_unit: done held until acknowledged
    always @(posedge clk) begin
        if (rst) begin
            mul_done <= 1'b0;
            mul_cnt  <= 0;
        end else begin
            if (mul_ack) mul_done <= 1'b0;
            if (mul_start) begin
                mul_cnt <= mul_lat;
                mul_res <= mul_calc(mul_op, mul_rs1, mul_rs2);
            end else if (mul_cnt == 1) begin
                mul_done <= 1'b1;
                mul_cnt  <= 0;
            end else if (mul_cnt > 1) begin
                mul_cnt <= mul_cnt - 1;
            end
        end
    end

    // div_unit: single-cycle done pulse, no ack
    always @(posedge clk) begin
        if (rst) begin
            div_done <= 1'b0;
            div_cnt  <= 0;
        end else begin
            if (div_done) div_done <= 1'b0;
            if (div_start) begin
                div_cnt <= div_lat;
                if (div_b == 32'd0) begin
                    div_q <= '1;
                    div_r <= div_a;
                end else if (div_op[0] == 1'b0) begin
                    div_q <= $signed(div_a) / $signed(div_b);
                    div_r <= $signed(div_a) % $signed(div_b);
                end else begin
                    div_q <= div_a / div_b;
                    div_r <= div_a % div_b;
                end
            end else if (div_cnt == 1) begin
                div_done <= 1'b1;
                div_cnt  <= 0;
            end else if (div_cnt > 1) begin
                div_cnt <= div_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_grant"}, 32'(bus.req_grant_o), 0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid_o), 0);
        chk({tag, "_start_ack"}, 32'({mul_start, div_start, mul_ack}), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_result"}, bus.resp_result_o, 0);
        chk({tag, "_mul_rs1"}, mul_rs1, 0);
        chk({tag, "_mul_rs2"}, mul_rs2, 0);
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit push);
        bus.req_valid_i[idx] = 1'b1;
        bus.req_op_i[idx]    = op;
        bus.req_rs1_i[idx]   = a;
        bus.req_rs2_i[idx]   = b;
        if (push) sb.push_back('{idx, exp, (op inside {3'd1, 3'd2, 3'd3})});
    endtask

    // Called at a negedge; returns at the second negedge after the grant.
    task automatic wait_grant(input int idx, input logic [1:0] exp_start);
        bit got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            #1;
            if (bus.req_grant_o != '0) got = 1'b1;
            else @(negedge clk);
        end
        chk("grant_seen", 32'(got), 1);
        if (got) begin
            chk("grant_onehot", 32'(bus.req_grant_o), 32'd1 << idx);
            last_grant_cyc = cyc;
        end
        @(negedge clk);
        bus.req_valid_i[idx] = 1'b0;
        bus.req_op_i[idx]    = 3'd0;
        if (got) begin
            chk("start_after_grant", 32'({mul_start, div_start}), 32'(exp_start));
            @(negedge clk);
            chk("start_one_cycle", 32'({mul_start, div_start}), 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bus.resp_ack_i = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.resp_valid_o != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_valid_o), 0);
                    bus.resp_ack_i = bus.resp_valid_o;
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", 32'(bus.resp_valid_o), 32'd1 << e.idx);
                    chk("resp_result", bus.resp_result_o, e.res);
                    bus.resp_ack_i = bus.resp_valid_o;
                    last_ack_cyc = cyc;
                    #1;
                    chk("mul_ack_on_resp_ack", 32'(mul_ack), 32'(e.is_mul));
                end
                @(negedge clk);
                bus.resp_ack_i = '0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit saw_grant;
        int idle_cyc;
        rst   = 1'b1;
        flush = 1'b0;
        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.req_rs1_i   = '0;
        bus.req_rs2_i   = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // MUL 3 x 5
        mul_lat = 2;
        set_req(0, OP_MUL, 32'd3, 32'd5, 32'd15, 1);
        wait_grant(0, 2'b10);

        // simultaneous: req0 DIV wins, req1 MULHU waits for ack + 1
        div_lat = 4;
        set_req(0, OP_DIV, 32'd100, 32'd7, 32'd14, 1);
        set_req(1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        wait_grant(0, 2'b01);
        wait_grant(1, 2'b10);
        chk("req1_grant_after_ack", 32'(last_grant_cyc), 32'(last_ack_cyc + 1));

        // zero divisor
        set_req(0, OP_DIVU, 32'd7, 32'd0, 32'd0, 1);
        wait_grant(0, 2'b00);
        set_req(1, OP_MODU, 32'd7, 32'd0, 32'd7, 1);
        wait_grant(1, 2'b00);
        set_req(0, OP_MOD, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
        wait_grant(0, 2'b00);

        // signed/unsigned divide and remainder selection
        set_req(0, OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
        wait_grant(0, 2'b01);
        set_req(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
        wait_grant(1, 2'b01);
        set_req(0, OP_MODU, 32'd100, 32'd7, 32'd2, 1);
        wait_grant(0, 2'b01);
        set_req(0, OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1);
        wait_grant(0, 2'b01);

        // req0 valid with op 0 is skipped; MUL high-word variants
        bus.req_valid_i[0] = 1'b1;
        set_req(1, OP_MULH, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1);
        wait_grant(1, 2'b10);
        bus.req_valid_i[0] = 1'b0;
        set_req(0, OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 1);
        wait_grant(0, 2'b10);
        set_req(1, OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1);
        wait_grant(1, 2'b10);

        // flush mid DIV_RUN: no response, requests blocked until div_done
        div_lat = 8;
        set_req(0, OP_DIV, 32'd50, 32'd5, 32'd0, 0);
        wait_grant(0, 2'b01);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        set_req(1, OP_MUL, 32'd2, 32'd3, 32'd6, 1);
        saw_grant = 1'b0;
        idle_cyc  = -1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            if (bus.req_grant_o != '0) saw_grant = 1'b1;
            @(negedge clk);
        end
        chk("drain_no_grant", 32'(saw_grant), 0);
        chk("drain_idle_after_done", 32'(idle_cyc), 32'(last_div_done_cyc + 1));
        wait_grant(1, 2'b10);

        // flush in the same cycle as mul_done: ack the unit, IDLE next cycle
        mul_lat = 3;
        set_req(0, OP_MUL, 32'd9, 32'd9, 32'd0, 0);
        wait_grant(0, 2'b10);
        for (int k = 0; k < 50; k++) begin
            if (mul_done) break;
            @(negedge clk);
        end
        chk("mul_done_seen", 32'(mul_done), 1);
        flush = 1'b1;
        #1;
        chk("flush_done_mul_ack", 32'(mul_ack), 1);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_idle", 32'(busy), 0);
        chk("flush_done_unit_released", 32'(mul_done), 0);

        // reset while in MUL_RUN, then a fresh MUL
        mul_lat = 5;
        set_req(0, OP_MUL, 32'd4, 32'd4, 32'd0, 0);
        wait_grant(0, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_in_run");
        mul_lat = 2;
        set_req(0, OP_MUL, 32'd7, 32'd6, 32'd42, 1);
        wait_grant(0, 2'b10);

        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
